// File: rtl/dvp_pkg.sv
// Shared encodings for the DVP test-pattern transmitter: FSM states,
// pattern select codes and the colour-bar palette.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAY  = 2'd1,
        PAT_SOLID = 2'd2,
        PAT_XY    = 2'd3
    } pattern_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Registered DVP pin payload.
    typedef struct packed {
        logic       vsync;
        logic       href;
        logic [7:0] data;
    } dvp_bus_t;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = BAR_WHITE;
            3'd1:    bar_color = BAR_YELLOW;
            3'd2:    bar_color = BAR_CYAN;
            3'd3:    bar_color = BAR_GREEN;
            3'd4:    bar_color = BAR_MAGENTA;
            3'd5:    bar_color = BAR_RED;
            3'd6:    bar_color = BAR_BLUE;
            default: bar_color = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_tx_if.sv
// DVP camera-side output bundle plus frame status, as seen by a sink.
interface dvp_tx_if;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    modport master (output vsync, href, data, frame_done, frame_cnt);
    modport slave  (input  vsync, href, data, frame_done, frame_cnt);
endinterface

// File: rtl/dvp_pattern.sv
// Combinational RGB565 test-pattern generator for pixel (x, y).
module dvp_pattern
    import dvp_pkg::*;
#(
    parameter int unsigned H_PIXEL = 800
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  pattern_e    sel,
    input  logic [15:0] solid,
    output logic [15:0] pixel
);

    localparam int unsigned BAR_W = (H_PIXEL / 8 > 0) ? H_PIXEL / 8 : 1;

    logic [15:0] bar_idx;

    always_comb begin
        bar_idx = x / 16'(BAR_W);
        pixel   = 16'h0000;
        case (sel)
            // Blanking x values can run past the last bar; hold the final colour.
            PAT_BARS:  pixel = bar_color((bar_idx > 16'd7) ? 3'd7 : bar_idx[2:0]);
            PAT_GRAY:  pixel = {x[7:3], x[7:2], x[7:3]};
            PAT_SOLID: pixel = solid;
            PAT_XY:    pixel = x + y;
            default:   pixel = 16'h0000;
        endcase
    end

endmodule

// File: rtl/dvp_tx.sv
// DVP (OV5640-style) frame transmitter: line/frame timing FSM driving
// vsync/href and two bytes per RGB565 test-pattern pixel.
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int unsigned H_PIXEL  = 800,
    parameter int unsigned V_PIXEL  = 480,
    parameter int unsigned H_BLANK  = 64,
    parameter int unsigned VS_LINES = 2,
    parameter int unsigned VB_PRE   = 4,
    parameter int unsigned VB_POST  = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tx_en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        ov5640_vsync,
    output logic        ov5640_href,
    output logic [7:0]  ov5640_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int unsigned LINE_TOTAL = 2 * H_PIXEL + H_BLANK;
    localparam int unsigned HREF_END   = 2 * H_PIXEL;
    localparam int unsigned HW         = $clog2(LINE_TOTAL + 1);
    localparam int unsigned LW         = $clog2(V_PIXEL + VS_LINES + VB_PRE + VB_POST + 1);

    state_e         state_q, state_d;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [LW-1:0]  lcnt_q, lcnt_d;
    logic [LW-1:0]  lines_in_state;
    logic           line_end;
    pattern_e       sel_q, sel_d;
    logic [15:0]    solid_q, solid_d;
    dvp_bus_t       bus_q, bus_d;
    logic           done_q, done_d;
    logic [15:0]    cnt_q;
    logic [15:0]    pixel;

    // State and counter registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Next-state: counters advance every cycle outside IDLE; states change on line boundaries.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        line_end = (hcnt_q == HW'(LINE_TOTAL - 1));
        case (state_q)
            ST_VSYNC:  lines_in_state = LW'(VS_LINES);
            ST_VBP:    lines_in_state = LW'(VB_PRE);
            ST_ACTIVE: lines_in_state = LW'(V_PIXEL);
            ST_VFP:    lines_in_state = LW'(VB_POST);
            default:   lines_in_state = '0;
        endcase

        if (state_q == ST_IDLE) begin
            hcnt_d = '0;
            lcnt_d = '0;
            if (tx_en) state_d = ST_VSYNC;
        end else begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            if (line_end) begin
                if (lcnt_q == lines_in_state - 1'b1) begin
                    lcnt_d = '0;
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBP;
                        ST_VBP:    state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFP;
                        ST_VFP:    state_d = tx_en ? ST_VSYNC : ST_IDLE;
                        default:   state_d = ST_IDLE;
                    endcase
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
        end
    end

    dvp_pattern #(.H_PIXEL(H_PIXEL)) u_pattern (
        .x     (16'(hcnt_d[HW-1:1])),
        .y     (16'(lcnt_d)),
        .sel   (sel_q),
        .solid (solid_q),
        .pixel (pixel)
    );

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        sel_d   = sel_q;
        solid_d = solid_q;
        if (state_d == ST_VSYNC && state_q != ST_VSYNC) begin
            sel_d   = pattern_e'(pattern_sel);
            solid_d = solid_rgb;
        end
        bus_d.vsync = (state_d == ST_VSYNC);
        bus_d.href  = (state_d == ST_ACTIVE) && (hcnt_d < HW'(HREF_END));
        bus_d.data  = bus_d.href ? (hcnt_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
        done_d      = (state_d == ST_VFP) && (lcnt_d == LW'(VB_POST - 1))
                   && (hcnt_d == HW'(LINE_TOTAL - 1));
    end

    // Output, pattern latch and frame counter registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_q   <= PAT_BARS;
            solid_q <= '0;
            bus_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            solid_q <= solid_d;
            bus_q   <= bus_d;
            done_q  <= done_d;
            cnt_q   <= cnt_q + 16'(done_d);
        end
    end

    assign ov5640_vsync = bus_q.vsync;
    assign ov5640_href  = bus_q.href;
    assign ov5640_data  = bus_q.data;
    assign frame_done   = done_q;
    assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_dvp_tx.sv
// Randomised scoreboard bench for dvp_tx: a frame-level reference model queues
// the expected pin state for every cycle of each frame; a monitor compares them.
module tb_dvp_tx;

    localparam int unsigned HP        = 8;
    localparam int unsigned VP        = 4;
    localparam int unsigned HB        = 4;
    localparam int unsigned VS        = 1;
    localparam int unsigned VBPRE     = 1;
    localparam int unsigned VBPOST    = 1;
    localparam int unsigned LT        = 2 * HP + HB;
    localparam int unsigned FRAME_CYC = LT * (VS + VBPRE + VP + VBPOST);

    typedef struct packed {
        logic        vs;
        logic        hr;
        logic [7:0]  d;
        logic        fd;
        logic [15:0] fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_en;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_rgb;

    dvp_tx_if vif ();

    dvp_tx #(
        .H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB),
        .VS_LINES(VS), .VB_PRE(VBPRE), .VB_POST(VBPOST)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .tx_en        (tx_en),
        .pattern_sel  (pattern_sel),
        .solid_rgb    (solid_rgb),
        .ov5640_vsync (vif.vsync),
        .ov5640_href  (vif.href),
        .ov5640_data  (vif.data),
        .frame_done   (vif.frame_done),
        .frame_cnt    (vif.frame_cnt)
    );

    always #5 clk = ~clk;

    obs_t        exp_q[$];
    int          checks     = 0;
    int          failures   = 0;
    int          done_seen  = 0;
    int          done_exp   = 0;
    logic [15:0] model_cnt  = 16'h0000;
    logic [15:0] bars[8]    = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    function automatic logic [15:0] model_pixel(input int sel, input logic [15:0] solid,
                                                input int x, input int y);
        int g;
        case (sel)
            0: return bars[x / (HP / 8)];
            1: begin
                g = x % 256;
                return 16'(((g / 8) * 2048) + ((g / 4) * 32) + (g / 8));
            end
            2: return solid;
            default: return 16'(x + y);
        endcase
    endfunction

    // Expected pin state for every cycle of one whole frame.
    task automatic push_frame(input logic [1:0] sel, input logic [15:0] solid);
        obs_t        o;
        int          line, h, y;
        logic [15:0] px;
        for (int j = 0; j < int'(FRAME_CYC); j++) begin
            line = j / int'(LT);
            h    = j % int'(LT);
            o    = '0;
            o.vs = (line < int'(VS));
            if (line >= int'(VS + VBPRE) && line < int'(VS + VBPRE + VP) && h < int'(2 * HP)) begin
                y    = line - int'(VS + VBPRE);
                px   = model_pixel(int'(sel), solid, h / 2, y);
                o.hr = 1'b1;
                o.d  = (h % 2 == 0) ? px[15:8] : px[7:0];
            end
            o.fd = (j == int'(FRAME_CYC) - 1);
            o.fc = o.fd ? model_cnt + 16'd1 : model_cnt;
            exp_q.push_back(o);
        end
        model_cnt = model_cnt + 16'd1;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a frame begins on any edge where nothing is in flight and tx_en is high.
    always @(posedge clk) begin
        if (rst_n && exp_q.size() == 0 && tx_en)
            push_frame(pattern_sel, solid_rgb);
    end

    // Monitor: compare the pins once per cycle, away from the active edge.
    always @(negedge clk) begin
        obs_t act, exp;
        act = {vif.vsync, vif.href, vif.data, vif.frame_done, vif.frame_cnt};
        exp = '0;
        if (rst_n) begin
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else exp.fc = model_cnt;
        end
        if (exp.fd) done_exp++;
        if (act.fd) done_seen++;
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL stream @%0t: got vs=%0b hr=%0b d=%02h fd=%0b fc=%04h, required vs=%0b hr=%0b d=%02h fd=%0b fc=%04h",
                     $time, act.vs, act.hr, act.d, act.fd, act.fc,
                     exp.vs, exp.hr, exp.d, exp.fd, exp.fc);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_pins_zero(input string tag);
        check_val({tag, "_vsync"}, 32'(vif.vsync), 32'd0);
        check_val({tag, "_href"},  32'(vif.href), 32'd0);
        check_val({tag, "_data"},  32'(vif.data), 32'd0);
        check_val({tag, "_done"},  32'(vif.frame_done), 32'd0);
        check_val({tag, "_cnt"},   32'(vif.frame_cnt), 32'd0);
    endtask

    // One frame, tx_en pulsed for a single sampled edge; pattern inputs scrambled mid-frame.
    task automatic single_frame(input logic [1:0] sel, input logic [15:0] solid, input bit scramble);
        @(negedge clk);
        pattern_sel = sel;
        solid_rgb   = solid;
        tx_en       = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        if (scramble) begin
            cycles(60);
            pattern_sel = 2'($urandom_range(0, 3));
            solid_rgb   = 16'($urandom);
            cycles(int'(FRAME_CYC) - 55);
        end else begin
            cycles(int'(FRAME_CYC) + 5);
        end
    endtask

    initial begin
        int done_before;
        rst_n       = 1'b0;
        tx_en       = 1'b0;
        pattern_sel = 2'd0;
        solid_rgb   = 16'h0000;
        #1;
        check_pins_zero("reset");
        cycles(3);
        #2 rst_n = 1'b1;
        cycles(8);

        single_frame(2'd0, 16'h0000, 1'b0);
        check_val("cnt_after_first", 32'(vif.frame_cnt), 32'd1);
        single_frame(2'd2, 16'h1234, 1'b0);
        single_frame(2'd1, 16'($urandom), 1'b0);

        // Back-to-back frames: x+y pattern, selection changed mid-frame, tx_en dropped in active line 2 of the second.
        @(negedge clk);
        pattern_sel = 2'd3;
        tx_en       = 1'b1;
        cycles(60);
        pattern_sel = 2'd0;
        solid_rgb   = 16'($urandom);
        cycles(225 - 60);
        tx_en = 1'b0;
        cycles(int'(FRAME_CYC));

        for (int i = 0; i < 4; i++)
            single_frame(2'($urandom_range(0, 3)), 16'($urandom), 1'b1);

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        #2;
        force dut.cnt_q = 16'hFFFF;
        model_cnt = 16'hFFFF;
        @(negedge clk);
        #2;
        release dut.cnt_q;
        single_frame(2'd3, 16'h0000, 1'b0);
        check_val("cnt_wrap", 32'(vif.frame_cnt), 32'd0);

        // Reset mid-ACTIVE aborts the frame with no frame_done.
        @(negedge clk);
        pattern_sel = 2'd1;
        tx_en       = 1'b1;
        cycles(70);
        done_before = done_seen;
        #2 rst_n = 1'b0;
        #1;
        check_pins_zero("midreset");
        exp_q.delete();
        model_cnt = 16'h0000;
        tx_en     = 1'b0;
        cycles(3);
        #2 rst_n = 1'b1;
        cycles(30);
        check_val("no_done_after_abort", 32'(done_seen), 32'(done_before));

        single_frame(2'($urandom_range(0, 3)), 16'($urandom), 1'b1);

        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        check_val("done_pulses", 32'(done_seen), 32'(done_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/dvp_tx.md
DVP_TX -- requirements
Module: dvp_tx

Interface
Parameters (one per line: name, default, meaning):
REQ-001 The block SHALL have parameter H_PIXEL, 800, active pixels per line.
REQ-002 The block SHALL have parameter V_PIXEL, 480, active lines per frame.
REQ-003 The block SHALL have parameter H_BLANK, 64, href-low byte cycles per line.
REQ-004 The block SHALL have parameter VS_LINES, 2, lines with vsync high.
REQ-005 The block SHALL have parameter VB_PRE, 4, blank lines between vsync and the first active line.
REQ-006 The block SHALL have parameter VB_POST, 4, blank lines after the last active line.

Ports (one per line: name, direction, width, meaning; clock and reset first):
REQ-007 The block SHALL have port sys_clk, in, 1, the only clock; it is also the byte clock forwarded as pclk.
REQ-008 The block SHALL have port sys_rst_n, in, 1, asynchronous active-low reset.
REQ-009 The block SHALL have port tx_en, in, 1, frame generation enable.
REQ-010 The block SHALL have port pattern_sel, in, 2, 0 colour bars, 1 gray ramp, 2 solid, 3 x+y count.
REQ-011 The block SHALL have port solid_rgb, in, 16, RGB565 value used for pattern 2.
REQ-012 The block SHALL have port ov5640_vsync, out, 1, frame sync, active high.
REQ-013 The block SHALL have port ov5640_href, out, 1, line valid, active high.
REQ-014 The block SHALL have port ov5640_data, out, 8, byte data.
REQ-015 The block SHALL have port frame_done, out, 1, one-cycle pulse at the end of each frame.
REQ-016 The block SHALL have port frame_cnt, out, 16, count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-017 All outputs SHALL be registered; only the registered outputs are visible at the ports.
REQ-018 Line length SHALL be LINE_TOTAL = 2*H_PIXEL + H_BLANK cycles; hcnt runs 0..LINE_TOTAL-1 and then wraps.
REQ-019 The FSM SHALL have the states IDLE, VSYNC, VBP, ACTIVE, VFP.
REQ-020 IDLE SHALL go to VSYNC on the cycle after tx_en is sampled high; hcnt and the line counter SHALL be 0 on entry to VSYNC.
REQ-021 VSYNC SHALL last VS_LINES lines, then go to VBP.
REQ-022 VBP SHALL last VB_PRE lines, then go to ACTIVE.
REQ-023 ACTIVE SHALL last V_PIXEL lines, then go to VFP.
REQ-024 VFP SHALL last VB_POST lines, then go to VSYNC if tx_en=1, else to IDLE.
REQ-025 ov5640_vsync SHALL be 1 exactly while the FSM is in VSYNC.
REQ-026 ov5640_href SHALL be 1 in ACTIVE while hcnt < 2*H_PIXEL, and 0 otherwise.
REQ-027 With x = hcnt/2 and y = the active line index, hcnt even SHALL output pixel[15:8] and hcnt odd SHALL output pixel[7:0].
REQ-028 ov5640_data SHALL be 0x00 whenever href is 0.
REQ-029 Pattern 0 SHALL be 8 bars, each H_PIXEL/8 wide: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-030 Pattern 1 SHALL be g = x[7:0], pixel = {g[7:3], g[7:2], g[7:3]}.
REQ-031 Pattern 2 SHALL be pixel = solid_rgb.
REQ-032 Pattern 3 SHALL be pixel = (x + y) truncated to 16 bits.
REQ-033 pattern_sel and solid_rgb SHALL be latched on entry to VSYNC; changes mid-frame SHALL take effect only at the next frame.
REQ-034 tx_en deasserted mid-frame SHALL NOT truncate the frame; the frame completes, then the FSM goes to IDLE.
REQ-035 frame_done SHALL pulse for one cycle on the last cycle of VFP, and frame_cnt SHALL increment in the same cycle.

Reset
REQ-036 On sys_rst_n low, the FSM SHALL go to IDLE asynchronously, and vsync, href, data, frame_done, frame_cnt, hcnt, the line counter and the latched pattern SHALL all be 0.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done pulse.
REQ-038 After reset release, the first frame SHALL start only once tx_en is sampled high in IDLE.

Structure
REQ-039 The shared package dvp_pkg SHALL hold the FSM state encoding, the eight colour-bar RGB565 constants and the pattern_sel codes.
REQ-040 One combinational sub-module, dvp_pattern (inputs x, y, sel, solid; output 16-bit pixel), SHALL generate the pixel values.
REQ-041 Timing counters and the FSM SHALL live in dvp_tx.

Verification
Bench parameters: H_PIXEL=8, V_PIXEL=4, H_BLANK=4, VS_LINES=1, VB_PRE=1, VB_POST=1, giving LINE_TOTAL=20 and 140 cycles per frame.
REQ-042 Bench SHALL drive tx_en=1 after reset -> vsync high for 20 cycles, then 20 cycles low, then 4 lines each with href high 16 cycles / low 4 cycles, then 20 cycles with href low, frame_done pulse at cycle 140, frame_cnt=1.
REQ-043 Bench SHALL drive pattern_sel=0 -> byte stream per line FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
REQ-044 Bench SHALL drive pattern_sel=2 with solid_rgb=0x1234 -> bytes 12 34 repeated, and data=00 during blanking.
REQ-045 Bench SHALL drive pattern_sel=3 -> line y=2 first pixel 0x0002 and last pixel 0x0009; bench SHALL change sel to 0 mid-frame -> current frame unchanged, next frame shows bars.
REQ-046 Bench SHALL drop tx_en in line 2 of ACTIVE -> frame completes, frame_done pulses, FSM enters IDLE, vsync stays 0.
REQ-047 Bench SHALL assert sys_rst_n low mid-ACTIVE -> all outputs 0 within the same cycle, no frame_done; bench SHALL preload frame_cnt=0xFFFF -> after the next frame_done frame_cnt=0x0000.
